// File: rtl/mem_responder_if.sv
// Initiator/responder bus for mem_responder: four-phase req/ack handshake,
// latched address/data, read data return and a busy indication.
interface mem_responder_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (output req, we, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory behind a four-phase req/ack handshake, with a
// self-clearing phase after reset and a combinational debug read port.
module mem_responder #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  mem_responder_if.slave    bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {CLEAR, IDLE, WAIT, ACCESS, ACK} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wval;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ack_d      = ack_q;
    rdata_d    = rdata_q;
    mem_wr     = 1'b0;
    mem_waddr  = addr_q;
    mem_wval   = wdata_q;

    case (state_q)
      CLEAR: begin
        mem_wr    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wval  = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
      end
      IDLE: begin
        if (bus.req) begin
          addr_d     = bus.addr;
          we_d       = bus.we;
          wdata_d    = bus.wdata;
          wait_cnt_d = WAIT_LOAD;
          state_d    = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ACCESS;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ACCESS: begin
        if (we_q) mem_wr  = 1'b1;
        else      rdata_d = mem_q[addr_q];
        ack_d   = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        // Only the falling req ends the handshake; bus inputs are ignored here.
        if (!bus.req) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  // Reset suppresses the array write so an in-flight access is dropped.
  always_ff @(posedge clock) begin
    if (!reset && mem_wr) mem_q[mem_waddr] <= mem_wval;
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != IDLE);
  assign dbg_data  = mem_q[dbg_addr];

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one DUT with one wait state, one with none,
// sharing clock and reset.
module tb_mem_responder;

  logic        clock;
  logic        reset;
  logic [5:0]  dbg_addr1, dbg_addr0;
  logic [15:0] dbg_data1, dbg_data0;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_responder_if #(.ADDR_W(6), .DATA_W(16)) bus1 ();
  mem_responder_if #(.ADDR_W(6), .DATA_W(16)) bus0 ();

  mem_responder #(.ADDR_W(6), .DATA_W(16), .WAIT_STATES(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1),
    .dbg_addr(dbg_addr1), .dbg_data(dbg_data1)
  );

  mem_responder #(.ADDR_W(6), .DATA_W(16), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0),
    .dbg_addr(dbg_addr0), .dbg_data(dbg_data0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [5:0] a, input logic [15:0] d);
    if (sel) begin
      bus1.req = r; bus1.we = w; bus1.addr = a; bus1.wdata = d;
    end else begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d;
    end
  endtask

  function automatic logic ack_of(input bit sel);
    return sel ? bus1.ack : bus0.ack;
  endfunction

  // Full handshake; lat = edges after the latching edge until ack, or -1 on timeout.
  task automatic run_xact(input bit sel, input logic w, input logic [5:0] a,
                          input logic [15:0] d, output int lat);
    drive(sel, 1'b1, w, a, d);
    tick();
    lat = 0;
    while (ack_of(sel) !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (ack_of(sel) !== 1'b1) lat = -1;
    drive(sel, 1'b0, 1'b0, 6'd0, 16'h0000);
    tick();
  endtask

  task automatic test_reset;
    int n;
    logic [5:0] probe [3] = '{6'd0, 6'd31, 6'd63};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (bus1.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 1", bus1.busy); end
    n_cmp++;
    if (bus1.ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b expected 0", bus1.ack); end
    n_cmp++;
    if (bus1.rdata !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0000", bus1.rdata); end
    n = 0;
    while (bus1.busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 64) begin n_fail++; $display("[TB] FAIL clear_cycles: got %0d expected 64", n); end
    n_cmp++;
    if (bus0.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_busy0: got %b expected 0", bus0.busy); end
    repeat (6) tick();
    foreach (probe[i]) begin
      dbg_addr1 = probe[i];
      #1;
      n_cmp++;
      if (dbg_data1 !== 16'h0000) begin
        n_fail++;
        $display("[TB] FAIL clear_dbg[%0d]: got %h expected 0000", probe[i], dbg_data1);
      end
    end
  endtask

  task automatic test_write_read;
    int lat;
    run_xact(1'b1, 1'b1, 6'd5, 16'hBEEF, lat);
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("[TB] FAIL wr_latency: got %0d expected 2", lat); end
    dbg_addr1 = 6'd5;
    #1;
    n_cmp++;
    if (dbg_data1 !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL wr_dbg: got %h expected beef", dbg_data1); end
    run_xact(1'b1, 1'b0, 6'd5, 16'h0000, lat);
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("[TB] FAIL rd_latency: got %0d expected 2", lat); end
    n_cmp++;
    if (bus1.rdata !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL rd_data: got %h expected beef", bus1.rdata); end
    n_cmp++;
    if (bus1.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_idle: got %b expected 0", bus1.busy); end
    run_xact(1'b1, 1'b1, 6'd6, 16'h1111, lat);
    n_cmp++;
    if (bus1.rdata !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL rdata_hold: got %h expected beef", bus1.rdata); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int held;
    run_xact(1'b0, 1'b1, 6'd63, 16'h1234, lat);
    run_xact(1'b0, 1'b1, 6'd0, 16'hABCD, lat);
    drive(1'b0, 1'b1, 1'b0, 6'd63, 16'h0000);
    tick();
    n_cmp++;
    if (bus0.ack !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_ack_early: got %b expected 0", bus0.ack); end
    tick();
    n_cmp++;
    if (bus0.ack !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ack_ws0: got %b expected 1", bus0.ack); end
    bus0.addr = 6'd0;
    held = 0;
    repeat (3) begin
      tick();
      if (bus0.ack === 1'b1) held++;
    end
    n_cmp++;
    if (held != 3) begin n_fail++; $display("[TB] FAIL b2b_ack_held: got %0d expected 3", held); end
    n_cmp++;
    if (bus0.rdata !== 16'h1234) begin n_fail++; $display("[TB] FAIL b2b_rdata63: got %h expected 1234", bus0.rdata); end
    bus0.req = 1'b0;
    tick();
    n_cmp++;
    if (bus0.ack !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_ack_fall: got %b expected 0", bus0.ack); end
    drive(1'b0, 1'b1, 1'b0, 6'd0, 16'h0000);
    tick();
    tick();
    n_cmp++;
    if (bus0.ack !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ack2: got %b expected 1", bus0.ack); end
    n_cmp++;
    if (bus0.rdata !== 16'hABCD) begin n_fail++; $display("[TB] FAIL b2b_rdata0: got %h expected abcd", bus0.rdata); end
    bus0.req = 1'b0;
    tick();
  endtask

  task automatic test_req_pulse;
    int lat;
    int high;
    int rises;
    logic prev;
    run_xact(1'b1, 1'b1, 6'd7, 16'h0707, lat);
    drive(1'b1, 1'b1, 1'b0, 6'd7, 16'h0000);
    tick();
    bus1.req = 1'b0;
    high = 0;
    rises = 0;
    prev = 1'b0;
    repeat (10) begin
      tick();
      if (bus1.ack === 1'b1) high++;
      if (bus1.ack === 1'b1 && prev === 1'b0) rises++;
      prev = bus1.ack;
    end
    n_cmp++;
    if (high != 1) begin n_fail++; $display("[TB] FAIL pulse_ack_cycles: got %0d expected 1", high); end
    n_cmp++;
    if (rises != 1) begin n_fail++; $display("[TB] FAIL pulse_accesses: got %0d expected 1", rises); end
    n_cmp++;
    if (bus1.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL pulse_idle: got %b expected 0", bus1.busy); end
    n_cmp++;
    if (bus1.rdata !== 16'h0707) begin n_fail++; $display("[TB] FAIL pulse_rdata: got %h expected 0707", bus1.rdata); end
  endtask

  task automatic test_ack_hold_write;
    dbg_addr1 = 6'd20;
    drive(1'b1, 1'b1, 1'b1, 6'd20, 16'h1357);
    tick();
    bus1.addr  = 6'd21;
    bus1.wdata = 16'h2468;
    tick();
    n_cmp++;
    if (dbg_data1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL hold_dbg_old: got %h expected 0000", dbg_data1); end
    tick();
    n_cmp++;
    if (bus1.ack !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_ack: got %b expected 1", bus1.ack); end
    n_cmp++;
    if (dbg_data1 !== 16'h1357) begin n_fail++; $display("[TB] FAIL hold_dbg_new: got %h expected 1357", dbg_data1); end
    bus1.addr  = 6'd22;
    bus1.wdata = 16'hAAAA;
    repeat (3) tick();
    bus1.req = 1'b0;
    tick();
    dbg_addr1 = 6'd21;
    #1;
    n_cmp++;
    if (dbg_data1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL hold_addr21: got %h expected 0000", dbg_data1); end
    dbg_addr1 = 6'd22;
    #1;
    n_cmp++;
    if (dbg_data1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL hold_addr22: got %h expected 0000", dbg_data1); end
    dbg_addr1 = 6'd20;
    #1;
    n_cmp++;
    if (dbg_data1 !== 16'h1357) begin n_fail++; $display("[TB] FAIL hold_addr20: got %h expected 1357", dbg_data1); end
  endtask

  task automatic test_reset_abort;
    int n;
    bit ack_seen;
    drive(1'b1, 1'b1, 1'b1, 6'd10, 16'h5555);
    drive(1'b0, 1'b1, 1'b1, 6'd12, 16'h7777);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 6'd0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
    ack_seen = (bus1.ack !== 1'b0) || (bus0.ack !== 1'b0);
    n_cmp++;
    if (bus1.rdata !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_rdata: got %h expected 0000", bus1.rdata); end
    n = 0;
    while (bus1.busy !== 1'b0 && n < 100) begin
      tick();
      n++;
      if (bus1.ack !== 1'b0 || bus0.ack !== 1'b0) ack_seen = 1'b1;
    end
    repeat (4) begin
      tick();
      if (bus1.ack !== 1'b0 || bus0.ack !== 1'b0) ack_seen = 1'b1;
    end
    n_cmp++;
    if (n != 64) begin n_fail++; $display("[TB] FAIL abort_clear_cycles: got %0d expected 64", n); end
    n_cmp++;
    if (ack_seen) begin n_fail++; $display("[TB] FAIL abort_ack: got 1 expected 0"); end
    dbg_addr1 = 6'd10;
    dbg_addr0 = 6'd12;
    #1;
    n_cmp++;
    if (dbg_data1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_addr10: got %h expected 0000", dbg_data1); end
    n_cmp++;
    if (dbg_data0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_addr12: got %h expected 0000", dbg_data0); end
  endtask

  initial begin
    reset = 1'b0;
    dbg_addr1 = '0;
    dbg_addr0 = '0;
    drive(1'b1, 1'b0, 1'b0, 6'd0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_req_pulse();
    test_ack_hold_write();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
